// File: rtl/ime_scan_ctrl_pkg.sv
// ime_scan_ctrl_pkg
//   Shared constants for the integer-ME scan sequencer: default PE count,
//   mvd width, search range and PE pipeline latency, plus FSM state codes.
//   No ports; imported by ime_scan_ctrl and its testbench.
package ime_scan_ctrl_pkg;

  localparam int IME_PE_NUM   = 4;   // PEs per step, horizontal stride
  localparam int IME_IMVD_LEN = 7;   // signed mvd component width
  localparam int IME_SR_X     = 16;  // x in [-SR_X, SR_X-PE_NUM]
  localparam int IME_SR_Y     = 16;  // y in [-SR_Y, SR_Y-1]
  localparam int IME_PE_LAT   = 2;   // pe_en_o -> PE cost valid latency

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ime_dly_line.sv
// ime_dly_line
//   Fixed-depth alignment pipe: a valid bit and a data word travel together
//   through DEPTH register stages, so out_* equals in_* exactly DEPTH cycles
//   later. Shifts every cycle (no stall input). Synchronous reset clears
//   both the valid chain and the data so outputs read zero after reset.
// Ports
//   clk    in   1      clock
//   rst    in   1      synchronous active-high reset
//   in_v   in   1      valid entering the pipe
//   in_d   in   WIDTH  data entering the pipe
//   out_v  out  1      valid, DEPTH cycles late
//   out_d  out  WIDTH  data, DEPTH cycles late
module ime_dly_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_v,
  output logic [WIDTH-1:0] out_d
);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_v;
      d_q[0] <= in_d;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_v = v_q[DEPTH-1];
  assign out_d = d_q[DEPTH-1];

endmodule

// File: rtl/ime_scan_ctrl.sv
// ime_scan_ctrl
//   Integer-ME search-window scan sequencer. Walks a candidate origin over
//   the window PE_NUM columns per step (raster order, x fastest), drives the
//   PE array, delays the step tag by PE_LAT so ime_mux sees cost_v/mvd
//   aligned, clears ime_mux at search start and pulses done_o once the mux
//   result is final.
//   Handshake: a step is issued on a cycle in SCAN where ref_rdy_i=1 (ref_rdy_i
//   is the ready for the next step); with ref_rdy_i=0 nothing is issued and
//   the position counters hold, so each position is issued exactly once.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  start a search (accepted in IDLE only)
//   ref_rdy_i                reference pixels for current step available
//   pe_en_o                  PE array evaluates (pe_mvd_x_o, pe_mvd_y_o)
//   pe_mvd_x_o, pe_mvd_y_o   PE0 candidate of the current step
//   rst_mux_o                clear ime_mux best cost
//   cost_v_o, mvd_x_o/_y_o   to ime_mux, PE_LAT cycles after issue
//   busy_o                   search in progress
//   done_o                   one-cycle pulse, ime_mux result final
//   dbg_state_o              FSM state for observation
module ime_scan_ctrl
  import ime_scan_ctrl_pkg::*;
#(
  parameter int PE_NUM   = IME_PE_NUM,
  parameter int IMVD_LEN = IME_IMVD_LEN,
  parameter int SR_X     = IME_SR_X,
  parameter int SR_Y     = IME_SR_Y,
  parameter int PE_LAT   = IME_PE_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                ref_rdy_i,
  output logic                pe_en_o,
  output logic [IMVD_LEN-1:0] pe_mvd_x_o,
  output logic [IMVD_LEN-1:0] pe_mvd_y_o,
  output logic                rst_mux_o,
  output logic                cost_v_o,
  output logic [IMVD_LEN-1:0] mvd_x_o,
  output logic [IMVD_LEN-1:0] mvd_y_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          dbg_state_o
);

  // rst_mux_o must never coincide with the first cost_v_o
  if (PE_LAT < 1) begin : g_bad_lat
    $error("ime_scan_ctrl: PE_LAT must be >= 1");
  end
  if (((2 * SR_X) % PE_NUM) != 0) begin : g_bad_stride
    $error("ime_scan_ctrl: 2*SR_X must be a multiple of PE_NUM");
  end

  localparam int DW = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

  localparam logic signed [IMVD_LEN-1:0] X_MIN  = IMVD_LEN'(-SR_X);
  localparam logic signed [IMVD_LEN-1:0] X_LAST = IMVD_LEN'(SR_X - PE_NUM);
  localparam logic signed [IMVD_LEN-1:0] Y_MIN  = IMVD_LEN'(-SR_Y);
  localparam logic signed [IMVD_LEN-1:0] Y_LAST = IMVD_LEN'(SR_Y - 1);
  localparam logic signed [IMVD_LEN-1:0] STRIDE = IMVD_LEN'(PE_NUM);
  localparam logic signed [IMVD_LEN-1:0] ONE    = IMVD_LEN'(1);

  logic [1:0]                 state;
  logic signed [IMVD_LEN-1:0] x_cnt;
  logic signed [IMVD_LEN-1:0] y_cnt;
  logic [DW-1:0]              drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      drain_cnt  <= '0;
      pe_en_o    <= 1'b0;
      pe_mvd_x_o <= '0;
      pe_mvd_y_o <= '0;
      rst_mux_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      // single-cycle strobes default low; pe_mvd_* keep last value
      pe_en_o   <= 1'b0;
      rst_mux_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state     <= ST_SCAN;
            rst_mux_o <= 1'b1;
            busy_o    <= 1'b1;
            x_cnt     <= X_MIN;
            y_cnt     <= Y_MIN;
          end
        end
        ST_SCAN: begin
          if (ref_rdy_i) begin
            pe_en_o    <= 1'b1;
            pe_mvd_x_o <= x_cnt;
            pe_mvd_y_o <= y_cnt;
            if (x_cnt == X_LAST) begin
              x_cnt <= X_MIN;
              if (y_cnt == Y_LAST) begin
                // last position issued this edge; wait for its cost
                state     <= ST_DRAIN;
                drain_cnt <= DW'(PE_LAT);
              end else begin
                y_cnt <= y_cnt + ONE;
              end
            end else begin
              x_cnt <= x_cnt + STRIDE;
            end
          end
        end
        ST_DRAIN: begin
          // PE_LAT+1 cycles in DRAIN: cost_v of the last step, then the
          // ime_mux register update, before done_o is raised
          if (drain_cnt == '0) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ime_dly_line #(
    .DEPTH (PE_LAT),
    .WIDTH (2 * IMVD_LEN)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .in_v  (pe_en_o),
    .in_d  ({pe_mvd_x_o, pe_mvd_y_o}),
    .out_v (cost_v_o),
    .out_d ({mvd_x_o, mvd_y_o})
  );

  assign dbg_state_o = state;

endmodule

// File: tb/tb_ime_scan_ctrl.sv
// tb_ime_scan_ctrl
//   Directed bench for ime_scan_ctrl: a default-parameter instance (u0) and a
//   small-window instance (u1: SR_X=4, SR_Y=2, PE_NUM=4, PE_LAT=1).
module tb_ime_scan_ctrl;
  import ime_scan_ctrl_pkg::*;

  localparam int W = IME_IMVD_LEN;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT u0 (defaults) ----------------
  logic         rst0, start0, ref_rdy0;
  logic         u0_pe_en, u0_rst_mux, u0_cost_v, u0_busy, u0_done;
  logic [W-1:0] u0_pe_mvd_x, u0_pe_mvd_y, u0_mvd_x, u0_mvd_y;
  logic [1:0]   u0_state;

  ime_scan_ctrl u0 (
    .clk         (clk),
    .rst         (rst0),
    .start_i     (start0),
    .ref_rdy_i   (ref_rdy0),
    .pe_en_o     (u0_pe_en),
    .pe_mvd_x_o  (u0_pe_mvd_x),
    .pe_mvd_y_o  (u0_pe_mvd_y),
    .rst_mux_o   (u0_rst_mux),
    .cost_v_o    (u0_cost_v),
    .mvd_x_o     (u0_mvd_x),
    .mvd_y_o     (u0_mvd_y),
    .busy_o      (u0_busy),
    .done_o      (u0_done),
    .dbg_state_o (u0_state)
  );

  // ---------------- DUT u1 (small window) ----------------
  logic         rst1, start1, ref_rdy1;
  logic         u1_pe_en, u1_rst_mux, u1_cost_v, u1_busy, u1_done;
  logic [W-1:0] u1_pe_mvd_x, u1_pe_mvd_y, u1_mvd_x, u1_mvd_y;
  logic [1:0]   u1_state;

  ime_scan_ctrl #(
    .PE_NUM (4), .IMVD_LEN (W), .SR_X (4), .SR_Y (2), .PE_LAT (1)
  ) u1 (
    .clk         (clk),
    .rst         (rst1),
    .start_i     (start1),
    .ref_rdy_i   (ref_rdy1),
    .pe_en_o     (u1_pe_en),
    .pe_mvd_x_o  (u1_pe_mvd_x),
    .pe_mvd_y_o  (u1_pe_mvd_y),
    .rst_mux_o   (u1_rst_mux),
    .cost_v_o    (u1_cost_v),
    .mvd_x_o     (u1_mvd_x),
    .mvd_y_o     (u1_mvd_y),
    .busy_o      (u1_busy),
    .done_o      (u1_done),
    .dbg_state_o (u1_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // planted SAD surface: unique minimum at candidate (-2,7)
  function automatic int pe_cost(input int x, input int y);
    return iabs(x + 2) + iabs(y - 7) + 1;
  endfunction

  // ---------------- scoreboard for u0 ----------------
  // reset as seen by the DUT at the last posedge
  logic rst0_smp = 1'b1;
  always @(posedge clk) rst0_smp <= rst0;

  // issue history: h1 = one cycle ago, h2 = two cycles ago (PE_LAT=2)
  logic h1_v = 1'b0, h2_v = 1'b0;
  int   h1_x = 0, h1_y = 0, h2_x = 0, h2_y = 0;
  int   n_iss = 0, n_cost = 0, last_iss_cyc = 0;
  int   best_cost = 32'h7fffffff, best_x = 0, best_y = 0;
  logic [W-1:0] exp_q[$];   // issued x positions awaiting their cost_v
  int   iss_x[256], iss_y[256];

  always @(negedge clk) begin
    int c;
    if (rst0_smp) begin
      h1_v = 1'b0;
      h2_v = 1'b0;
      exp_q.delete();
    end
    if (u0_rst_mux) begin
      n_iss = 0;
      n_cost = 0;
      best_cost = 32'h7fffffff;
      best_x = 0;
      best_y = 0;
    end
    if (h2_v || u0_cost_v) begin
      check("align_cost_v", int'(u0_cost_v), int'(h2_v));
      if (h2_v) begin
        check("align_mvd_x", sx(u0_mvd_x), h2_x);
        check("align_mvd_y", sx(u0_mvd_y), h2_y);
      end
    end
    if (u0_cost_v) begin
      n_cost++;
      if (exp_q.size() > 0) begin
        check("cost_order_x", sx(u0_mvd_x), sx(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        check("cost_without_issue", 1, 0);
      end
      // ime_mux model: strict less-than keeps the first minimum
      for (int k = 0; k < 4; k++) begin
        c = pe_cost(sx(u0_mvd_x) + k, sx(u0_mvd_y));
        if (c < best_cost) begin
          best_cost = c;
          best_x = sx(u0_mvd_x) + k;
          best_y = sx(u0_mvd_y);
        end
      end
    end
    if (u0_pe_en) begin
      // raster order: 8 steps of stride 4 per row
      check("seq_x", sx(u0_pe_mvd_x), -16 + 4 * (n_iss % 8));
      check("seq_y", sx(u0_pe_mvd_y), -16 + n_iss / 8);
      if (n_iss < 256) begin
        iss_x[n_iss] = sx(u0_pe_mvd_x);
        iss_y[n_iss] = sx(u0_pe_mvd_y);
      end
      exp_q.push_back(u0_pe_mvd_x);
      n_iss++;
      last_iss_cyc = cyc;
    end
    if (u0_done) begin
      check("done_steps", n_iss, 256);
      check("done_costs", n_cost, 256);
      check("done_latency", cyc - last_iss_cyc, 3);
      check("mux_best_x", best_x, -2);
      check("mux_best_y", best_y, 7);
      check("step1_x", iss_x[0], -16);
      check("step1_y", iss_y[0], -16);
      check("step2_x", iss_x[1], -12);
      check("step9_x", iss_x[8], -16);
      check("step9_y", iss_y[8], -15);
      check("step256_x", iss_x[255], 12);
      check("step256_y", iss_y[255], 15);
    end
    h2_v = h1_v; h2_x = h1_x; h2_y = h1_y;
    h1_v = u0_pe_en; h1_x = sx(u0_pe_mvd_x); h1_y = sx(u0_pe_mvd_y);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done0(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (u0_done) ok = 1'b1;
    end
  endtask

  task automatic wait_issue0(input int x, input int y, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (u0_pe_en && sx(u0_pe_mvd_x) == x && sx(u0_pe_mvd_y) == y) ok = 1'b1;
    end
  endtask

  task automatic check_u0_zero(input string tag);
    check({tag, "_pe_en"},   int'(u0_pe_en), 0);
    check({tag, "_pe_x"},    int'(u0_pe_mvd_x), 0);
    check({tag, "_pe_y"},    int'(u0_pe_mvd_y), 0);
    check({tag, "_rst_mux"}, int'(u0_rst_mux), 0);
    check({tag, "_cost_v"},  int'(u0_cost_v), 0);
    check({tag, "_mvd_x"},   int'(u0_mvd_x), 0);
    check({tag, "_mvd_y"},   int'(u0_mvd_y), 0);
    check({tag, "_busy"},    int'(u0_busy), 0);
    check({tag, "_done"},    int'(u0_done), 0);
    check({tag, "_state"},   int'(u0_state), int'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  int xs1[8] = '{-4, 0, -4, 0, -4, 0, -4, 0};
  int ys1[8] = '{-2, -2, -1, -1, 0, 0, 1, 1};

  initial begin
    bit ok;
    int k, last1, prev_en, prev_x, prev_y;

    rst0 = 1'b1; start0 = 1'b0; ref_rdy0 = 1'b1;
    rst1 = 1'b1; start1 = 1'b0; ref_rdy1 = 1'b1;
    repeat (3) @(negedge clk);
    check_u0_zero("reset");
    check("reset_u1_pe_en", int'(u1_pe_en), 0);
    check("reset_u1_busy", int'(u1_busy), 0);

    // ---- search 1: start at cycle 0 ----
    rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b1;
    @(negedge clk);                          // cycle 1
    start0 = 1'b0;
    check("c1_rst_mux", int'(u0_rst_mux), 1);
    check("c1_busy", int'(u0_busy), 1);
    check("c1_pe_en", int'(u0_pe_en), 0);
    check("c1_state", int'(u0_state), int'(ST_SCAN));
    @(negedge clk);                          // cycle 2
    check("c2_rst_mux", int'(u0_rst_mux), 0);
    check("c2_pe_en", int'(u0_pe_en), 1);
    check("c2_x", sx(u0_pe_mvd_x), -16);
    check("c2_y", sx(u0_pe_mvd_y), -16);
    @(negedge clk);                          // cycle 3
    check("c3_x", sx(u0_pe_mvd_x), -12);
    check("c3_cost_v", int'(u0_cost_v), 0);

    // start pulse mid-scan must be ignored
    repeat (5) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("scan_start_ignored", int'(u0_rst_mux), 0);
    check("scan_start_state", int'(u0_state), int'(ST_SCAN));

    // stall 5 cycles with x_cnt=0, y=3 (i.e. just after (-4,3) issued)
    wait_issue0(-4, 3, 400, ok);
    check("stall_reached", int'(ok), 1);
    ref_rdy0 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("stall_pe_en", int'(u0_pe_en), 0);
      if (i == 5) ref_rdy0 = 1'b1;
    end
    @(negedge clk);
    check("resume_pe_en", int'(u0_pe_en), 1);
    check("resume_x", sx(u0_pe_mvd_x), 0);
    check("resume_y", sx(u0_pe_mvd_y), 3);

    wait_done0(1000, ok);
    check("search1_done_seen", int'(ok), 1);
    check("done_busy", int'(u0_busy), 1);
    check("done_state", int'(u0_state), int'(ST_DONE));
    start0 = 1'b1;                           // ignored in done cycle
    @(negedge clk);
    check("post_done_busy", int'(u0_busy), 0);
    check("post_done_done", int'(u0_done), 0);
    check("done_start_ignored", int'(u0_rst_mux), 0);
    @(negedge clk);                          // start accepted in IDLE
    start0 = 1'b0;
    check("restart_rst_mux", int'(u0_rst_mux), 1);
    check("restart_busy", int'(u0_busy), 1);

    // ---- search 2: reset at step 100 ----
    wait_issue0(-4, -4, 400, ok);            // 100th issued step
    check("step100_reached", int'(ok), 1);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check_u0_zero("midrst");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_cost", int'(u0_cost_v), 0);
      check("midrst_no_pe", int'(u0_pe_en), 0);
    end

    // ---- search 3: clean full scan after reset ----
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("s3_rst_mux", int'(u0_rst_mux), 1);
    wait_done0(1000, ok);
    check("search3_done_seen", int'(ok), 1);
    @(negedge clk);
    check("s3_idle", int'(u0_state), int'(ST_IDLE));

    // ---- small window on u1 ----
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("u1_rst_mux", int'(u1_rst_mux), 1);
    k = 0; last1 = 0; ok = 1'b0;
    prev_en = 0; prev_x = 0; prev_y = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (prev_en != 0 || u1_cost_v) begin
        check("u1_align_cost_v", int'(u1_cost_v), prev_en);
        if (prev_en != 0) begin
          check("u1_align_x", sx(u1_mvd_x), prev_x);
          check("u1_align_y", sx(u1_mvd_y), prev_y);
        end
      end
      if (u1_pe_en) begin
        if (k < 8) begin
          check("u1_seq_x", sx(u1_pe_mvd_x), xs1[k]);
          check("u1_seq_y", sx(u1_pe_mvd_y), ys1[k]);
        end
        k++;
        last1 = c;
      end
      if (u1_done) begin
        ok = 1'b1;
        check("u1_steps", k, 8);
        check("u1_done_latency", c - last1, 2);
        check("u1_done_busy", int'(u1_busy), 1);
      end
      prev_en = int'(u1_pe_en); prev_x = sx(u1_pe_mvd_x); prev_y = sx(u1_pe_mvd_y);
    end
    check("u1_done_seen", int'(ok), 1);
    @(negedge clk);
    check("u1_idle_busy", int'(u1_busy), 0);

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
